// File: rtl/nibble_serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl_if
// Description : Operand/result valid-ready bundle for nibble_serial_adder_ctrl.
//               The op port exists only when NIBBLE_SERIAL_ADDER_SUB_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_ctrl_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic         op;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         co;
    logic         busy;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    modport master (
        output in_valid, a, b, ci, op, out_ready,
        input  in_ready, out_valid, sum, co, busy
    );
    modport slave (
        input  in_valid, a, b, ci, op, out_ready,
        output in_ready, out_valid, sum, co, busy
    );
`else
    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, sum, co, busy
    );
    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, sum, co, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : W-bit adder built from one 4-bit ripple slice, one nibble per
//               clock, LSB nibble first. NIBBLE_SERIAL_ADDER_SUB_EN adds a - b.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    nibble_serial_adder_ctrl_if.slave bus
);
    localparam int         W      = 4 * NIBBLES;
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [3:0] c_LAST = 4'(NIBBLES - 1);

    logic [1:0]   state_q,  state_d;
    logic [W-1:0] a_sh_q,   a_sh_d;
    logic [W-1:0] b_sh_q,   b_sh_d;
    logic [W-1:0] sum_sh_q, sum_sh_d;
    logic         carry_q,  carry_d;
    logic [3:0]   cnt_q,    cnt_d;

    logic [3:0]   w_slice_sum;
    logic         w_slice_co;
    logic [W-1:0] w_b_load;
    logic         w_carry_load;

    // Four chained full adders; the inter-nibble carry lives only in carry_q.
    always_comb begin
        logic c;
        c           = carry_q;
        w_slice_sum = 4'd0;
        for (int i = 0; i < 4; i++) begin
            w_slice_sum[i] = a_sh_q[i] ^ b_sh_q[i] ^ c;
            c              = (a_sh_q[i] & b_sh_q[i]) | (c & (a_sh_q[i] ^ b_sh_q[i]));
        end
        w_slice_co = c;
    end

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    assign w_b_load     = bus.op ? ~bus.b : bus.b;
    assign w_carry_load = bus.op ? 1'b1   : bus.ci;
`else
    assign w_b_load     = bus.b;
    assign w_carry_load = bus.ci;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= c_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        case (state_q)
            c_IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = w_b_load;
                    carry_d = w_carry_load;
                    cnt_d   = 4'd0;
                    state_d = c_RUN;
                end
            end
            c_RUN: begin
                a_sh_d   = a_sh_q >> 4;
                b_sh_d   = b_sh_q >> 4;
                sum_sh_d = (sum_sh_q >> 4) | (W'(w_slice_sum) << (W - 4));
                carry_d  = w_slice_co;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == c_LAST) begin
                    state_d = c_DONE;
                end
            end
            c_DONE: begin
                if (bus.out_ready) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Result is gated so partial sums never appear outside DONE.
    always_comb begin
        bus.in_ready  = (state_q == c_IDLE);
        bus.out_valid = (state_q == c_DONE);
        bus.busy      = (state_q != c_IDLE);
        bus.sum       = (state_q == c_DONE) ? sum_sh_q : '0;
        bus.co        = (state_q == c_DONE) & carry_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_adder_ctrl
// Description : Directed bench for a 4-nibble and a 1-nibble instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.W(16)) bus ();
    nibble_serial_adder_ctrl_if #(.W(4))  bus1 ();

    nibble_serial_adder_ctrl #(.NIBBLES(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid4(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_valid1(output int lat);
        lat = 0;
        while (bus1.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run4(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic op,
                        input logic [15:0] es, input logic ec);
        int lat;
        bus.a = a; bus.b = b; bus.ci = ci;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        bus.op = op;
`else
        if (op) $display("note: op ignored in add-only build");
`endif
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        chk({tag, ".in_ready_idle"}, bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk({tag, ".busy_run"}, bus.busy, 1);
        chk({tag, ".in_ready_run"}, bus.in_ready, 0);
        wait_valid4(lat);
        chk({tag, ".latency"}, lat, 4);
        chk({tag, ".sum"}, bus.sum, es);
        chk({tag, ".co"}, bus.co, ec);
        tick();
        chk({tag, ".valid_pulse"}, bus.out_valid, 0);
    endtask

    initial begin
        int  lat;
        logic seen;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.ci = 1'b0; bus1.out_ready = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        bus.op = 1'b0; bus1.op = 1'b0;
`endif
        tick(); tick();
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.sum", bus.sum, 0);
        chk("rst.co", bus.co, 0);
        chk("rst.busy", bus.busy, 0);
        rst = 1'b0;
        tick();
        chk("rst.in_ready", bus.in_ready, 1);

        run4("v1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
        run4("vffff1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        run4("vffffci", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
        run4("vabcd", 16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0);
        run4("v8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Backpressure with a competing operand held on the input side.
        bus.a = 16'h00F0; bus.b = 16'h0010; bus.ci = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        tick();
        bus.a = 16'h1111; bus.b = 16'h1111;
        wait_valid4(lat);
        chk("bp.latency", lat, 4);
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", bus.out_valid, 1);
            chk("bp.sum", bus.sum, 16'h0100);
            chk("bp.co", bus.co, 0);
            chk("bp.in_ready", bus.in_ready, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp.idle_valid", bus.out_valid, 0);
        chk("bp.idle_in_ready", bus.in_ready, 1);
        chk("bp.idle_busy", bus.busy, 0);
        tick();
        bus.in_valid = 1'b0;
        wait_valid4(lat);
        chk("bp.next_latency", lat, 4);
        chk("bp.next_sum", bus.sum, 16'h2222);
        chk("bp.next_co", bus.co, 0);
        tick();

        // Reset two cycles into an operation.
        bus.a = 16'h8888; bus.b = 16'h8888; bus.ci = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("mrst.valid", bus.out_valid, 0);
        chk("mrst.busy", bus.busy, 0);
        chk("mrst.sum", bus.sum, 0);
        chk("mrst.co", bus.co, 0);
        rst = 1'b0;
        chk("mrst.in_ready", bus.in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen = seen | bus.out_valid;
            tick();
        end
        chk("mrst.no_valid", seen, 0);
        run4("mrst.after", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);

        // Single-nibble instance.
        bus1.a = 4'hF; bus1.b = 4'h1; bus1.ci = 1'b0;
        bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        wait_valid1(lat);
        chk("n1.latency", lat, 1);
        chk("n1.sum", bus1.sum, 4'h0);
        chk("n1.co", bus1.co, 1);
        tick();
        chk("n1.valid_pulse", bus1.out_valid, 0);
        bus1.a = 4'h3; bus1.b = 4'h4; bus1.ci = 1'b1;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        wait_valid1(lat);
        chk("n1b.latency", lat, 1);
        chk("n1b.sum", bus1.sum, 4'h8);
        chk("n1b.co", bus1.co, 0);
        tick();

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        run4("sub57", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        run4("sub75", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
        run4("subeq", 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1);
        run4("subadd", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
